// File: rtl/data_mem_resp.sv
// Data-memory responder for the MEM stage: one load/store at a time, fixed access
// latency, byte-lane store merge, sign/zero-extended loads and access checking.
module data_mem_resp #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [63:0] mem_addr,
    input  logic [63:0] write_data,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [63:0] read_data,
    output logic        access_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    // Handshake: a request is taken on a rising edge where req_valid & req_ready;
    // the response is valid only in the single cycle where resp_valid is high.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  count, count_next;
    logic [63:0] mem [DEPTH];
    logic [63:0] pend_data;
    logic        pend_err;

    logic [AW-1:0] index;
    logic [2:0]    offset;
    logic [1:0]    size;
    logic          misaligned, out_of_range, illegal, err;
    logic          accept, mem_we;
    logic [7:0]    lane_mask, byte_en;
    logic [63:0]   row, wdata_shifted, merged, row_shifted, load_ext, fresh_data;

    assign index        = mem_addr[AW+2:3];
    assign offset       = mem_addr[2:0];
    assign size         = funct3[1:0];
    assign out_of_range = |mem_addr[63:AW+3];
    assign illegal      = (funct3 == 3'b111);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = offset[0];
            2'd2:    misaligned = |offset[1:0];
            default: misaligned = |offset;
        endcase
    end

    assign err = misaligned | out_of_range | illegal;

    always_comb begin
        lane_mask = 8'h00;
        case (size)
            2'd0:    lane_mask = 8'h01;
            2'd1:    lane_mask = 8'h03;
            2'd2:    lane_mask = 8'h0F;
            default: lane_mask = 8'hFF;
        endcase
    end

    assign row           = mem[index];
    assign byte_en       = lane_mask << offset;
    assign wdata_shifted = write_data << {offset, 3'b000};
    assign row_shifted   = row >> {offset, 3'b000};

    always_comb begin
        merged = row;
        for (int i = 0; i < 8; i++) begin
            if (byte_en[i]) merged[8*i +: 8] = wdata_shifted[8*i +: 8];
        end
    end

    always_comb begin
        load_ext = 64'd0;
        case (funct3)
            3'b000:  load_ext = {{56{row_shifted[7]}}, row_shifted[7:0]};
            3'b001:  load_ext = {{48{row_shifted[15]}}, row_shifted[15:0]};
            3'b010:  load_ext = {{32{row_shifted[31]}}, row_shifted[31:0]};
            3'b011:  load_ext = row_shifted;
            3'b100:  load_ext = {56'd0, row_shifted[7:0]};
            3'b101:  load_ext = {48'd0, row_shifted[15:0]};
            3'b110:  load_ext = {32'd0, row_shifted[31:0]};
            default: load_ext = 64'd0;
        endcase
    end

    assign fresh_data = (req_write | err) ? 64'd0 : load_ext;
    assign accept     = req_ready & req_valid;
    // Gated by reset so a request presented while reset is held never commits.
    assign mem_we     = accept & req_write & ~err & reset;

    always_comb begin
        state_next = state;
        count_next = count;
        req_ready  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    count_next = LAT_M1;
                    state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                count_next = count - 4'd1;
                if (count == 4'd1) state_next = S_RESP;
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign resp_valid = (state == S_RESP);
    assign stall      = req_valid & ~resp_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            count      <= 4'd0;
            pend_data  <= 64'd0;
            pend_err   <= 1'b0;
            read_data  <= 64'd0;
            access_err <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                pend_data <= fresh_data;
                pend_err  <= err;
            end
            // With LATENCY=1 the response is loaded straight from the accepting cycle.
            if (state_next == S_RESP) begin
                read_data  <= (state == S_IDLE) ? fresh_data : pend_data;
                access_err <= (state == S_IDLE) ? err : pend_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[index] <= merged;
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: byte-addressed reference model feeding an expected-response
// queue, a negedge monitor popping it, plus a LATENCY=1 instance for back-to-back loads.
module tb_data_mem_resp;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [2:0]  funct3;
    logic [63:0] mem_addr, write_data;
    logic        req_ready, stall, resp_valid, access_err;
    logic [63:0] read_data;

    logic        req_valid1, req_write1;
    logic [2:0]  funct31;
    logic [63:0] mem_addr1, write_data1;
    logic        req_ready1, stall1, resp_valid1, access_err1;
    logic [63:0] read_data1;

    logic [64:0] exp_q[$];
    logic [7:0]  ref_mem [DEPTH*8];
    int n_tests = 0;
    int n_fail  = 0;

    data_mem_resp #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .mem_addr(mem_addr), .write_data(write_data),
        .req_ready(req_ready), .stall(stall), .resp_valid(resp_valid),
        .read_data(read_data), .access_err(access_err)
    );

    data_mem_resp #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_write(req_write1),
        .funct3(funct31), .mem_addr(mem_addr1), .write_data(write_data1),
        .req_ready(req_ready1), .stall(stall1), .resp_valid(resp_valid1),
        .read_data(read_data1), .access_err(access_err1)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, rules applied directly.
    function automatic logic [64:0] model_access(input logic wr, input logic [2:0] f3,
                                                 input logic [63:0] addr, input logic [63:0] wd);
        int          nbytes;
        logic        bad;
        logic [63:0] val;
        nbytes = 1 << f3[1:0];
        bad = (f3 == 3'b111) || ((addr % nbytes) != 0) || (addr >= 64'(DEPTH * 8));
        if (bad) return {1'b1, 64'd0};
        if (wr) begin
            for (int i = 0; i < nbytes; i++) ref_mem[addr + 64'(i)] = wd[8*i +: 8];
            return 65'd0;
        end
        val = 64'd0;
        for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[addr + 64'(i)];
        if (!f3[2] && nbytes < 8 && val[8*nbytes-1])
            for (int i = nbytes; i < 8; i++) val[8*i +: 8] = 8'hFF;
        return {1'b0, val};
    endfunction

    // monitor
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            logic [64:0] e;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_resp: resp_valid with empty expected queue at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("read_data", read_data, e[63:0]);
                check("access_err", {63'd0, access_err}, {63'd0, e[64]});
                check("ready_in_resp", {63'd0, req_ready}, 64'd0);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd);
        @(posedge clk); #2;
        req_valid  = 1'b1;
        req_write  = wr;
        funct3     = f3;
        mem_addr   = addr;
        write_data = wd;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wd, input logic use_exp, input logic [64:0] exp_v);
        logic [64:0] m;
        int cyc, st;
        bit got;
        m = model_access(wr, f3, addr, wd);
        drive(wr, f3, addr, wd);
        exp_q.push_back(use_exp ? exp_v : m);
        cyc = 0; st = 0; got = 0;
        while (cyc < 20 && !got) begin
            @(negedge clk);
            cyc++;
            if (stall) st++;
            if (resp_valid) got = 1;
            else if (cyc == 2) begin
                // scramble inputs while waiting; the latched request must win
                req_write  = 1'($urandom_range(0, 1));
                funct3     = 3'($urandom_range(0, 7));
                mem_addr   = {$urandom, $urandom};
                write_data = {$urandom, $urandom};
            end
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: no resp_valid within 20 cycles for addr %h", addr);
        end else begin
            check("resp_latency", 64'(cyc), 64'(LAT + 1));
            check("stall_cycles", 64'(st), 64'(LAT));
        end
        @(posedge clk); #2;
        req_valid = 1'b0;
        @(negedge clk);
        check("idle_stall", {63'd0, stall}, 64'd0);
        check("idle_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] v;
        logic [2:0]  f3;
        logic [63:0] addr;
        int          r, nbytes;

        reset = 1'b0;
        req_valid = 0; req_write = 0; funct3 = 0; mem_addr = 0; write_data = 0;
        req_valid1 = 0; req_write1 = 0; funct31 = 0; mem_addr1 = 0; write_data1 = 0;
        repeat (2) @(negedge clk);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_read_data", read_data, 64'd0);
        check("rst_access_err", {63'd0, access_err}, 64'd0);
        check("rst_req_ready", {63'd0, req_ready}, 64'd1);
        check("rst_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #2;
        reset = 1'b1;

        // fill every doubleword so later loads see defined data
        for (int i = 0; i < DEPTH; i++)
            do_req(1'b1, 3'b011, 64'(i * 8), {$urandom, $urandom}, 1'b0, 65'd0);

        // directed cases with literal expectations
        do_req(1, 3'b011, 64'h10, 64'h1122334455667788, 1, {1'b0, 64'd0});
        do_req(0, 3'b011, 64'h10, 64'd0, 1, {1'b0, 64'h1122334455667788});
        do_req(1, 3'b000, 64'h13, 64'h00000000000000AA, 1, {1'b0, 64'd0});
        do_req(0, 3'b000, 64'h13, 64'd0, 1, {1'b0, 64'hFFFFFFFFFFFFFFAA});
        do_req(0, 3'b100, 64'h13, 64'd0, 1, {1'b0, 64'h00000000000000AA});
        do_req(0, 3'b011, 64'h10, 64'd0, 1, {1'b0, 64'h11223344AA667788});
        do_req(1, 3'b010, 64'h20, 64'h0000000080000001, 1, {1'b0, 64'd0});
        do_req(0, 3'b010, 64'h20, 64'd0, 1, {1'b0, 64'hFFFFFFFF80000001});
        do_req(0, 3'b110, 64'h20, 64'd0, 1, {1'b0, 64'h0000000080000001});
        do_req(0, 3'b001, 64'h21, 64'd0, 1, {1'b1, 64'd0});
        do_req(1, 3'b011, 64'(DEPTH * 8), 64'hDEADBEEFDEADBEEF, 1, {1'b1, 64'd0});
        do_req(0, 3'b011, 64'h0, 64'd0, 0, 65'd0);
        do_req(0, 3'b111, 64'h8, 64'd0, 1, {1'b1, 64'd0});
        do_req(1, 3'b001, 64'h33, 64'hFFFF, 1, {1'b1, 64'd0});
        do_req(0, 3'b011, 64'h30, 64'd0, 0, 65'd0);

        // randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            f3 = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            if (r == 0)      addr = 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
            else if (r == 1) addr = {$urandom, $urandom};
            else             addr = 64'($urandom_range(0, DEPTH * 8 - 1));
            nbytes = 1 << f3[1:0];
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'(nbytes - 1);
            do_req(1'($urandom_range(0, 2) == 0), f3, addr, {$urandom, $urandom}, 1'b0, 65'd0);
        end

        // reset while a load is pending
        v = {$urandom, $urandom} | 64'h1;
        do_req(1, 3'b011, 64'h40, v, 0, 65'd0);
        do_req(0, 3'b011, 64'h40, 64'd0, 0, 65'd0);
        drive(1'b0, 3'b011, 64'h48, 64'd0);
        @(posedge clk); #2;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_read_data", read_data, 64'd0);
        check("midrst_access_err", {63'd0, access_err}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("postrst_no_resp", {63'd0, resp_valid}, 64'd0);
        end
        do_req(0, 3'b011, 64'h40, 64'd0, 1, {1'b0, v});

        // LATENCY=1 instance: one store, then loads with req_valid held high
        v = {$urandom, $urandom};
        @(posedge clk); #2;
        req_valid1 = 1; req_write1 = 1; funct31 = 3'b011; mem_addr1 = 64'h18; write_data1 = v;
        @(posedge clk); #2;
        req_valid1 = 0;
        @(posedge clk); #2;
        req_valid1 = 1; req_write1 = 0; funct31 = 3'b011; mem_addr1 = 64'h18;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("l1_resp_valid", {63'd0, resp_valid1}, 64'(i % 2));
            check("l1_req_ready", {63'd0, req_ready1}, 64'(1 - (i % 2)));
            check("l1_stall", {63'd0, stall1}, 64'(1 - (i % 2)));
            if (i % 2 == 1) begin
                check("l1_read_data", read_data1, v);
                check("l1_access_err", {63'd0, access_err1}, 64'd0);
            end
        end
        @(posedge clk); #2;
        req_valid1 = 0;

        repeat (5) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder for the MEM stage of the 64-bit RISC-V pipeline.
- Accepts one load/store request at a time from EX/MEM outputs and holds the pipeline via `stall` for a fixed access latency.
- Returns sign/zero-extended load data on `read_data`, which feeds the MEM/WB `read_data_in` input.
- Owns the doubleword storage array, byte-lane store merging, and alignment/range checks.

Parameters:
- DEPTH, 256, number of 64-bit doublewords in the array (power of two).
- LATENCY, 2, cycles from request acceptance to response (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  MEM-stage access request (MemRead | MemWrite from EX/MEM).
- req_write  input  1  1 = store, 0 = load; sampled on acceptance.
- funct3  input  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- mem_addr  input  64  byte address (ALU result from EX/MEM).
- write_data  input  64  store data; low bytes are used for sub-doubleword stores.
- req_ready  output  1  1 only in IDLE.
- stall  output  1  freeze PC/IF/ID/ID/EX/EX/MEM while 1.
- resp_valid  output  1  one-cycle pulse marking the response cycle.
- read_data  output  64  extended load data; valid when resp_valid=1.
- access_err  output  1  pulses with resp_valid on a misaligned, out-of-range, or illegal-funct3 access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0.
  - resp_valid=0, read_data=0, access_err=0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid=1, the request is accepted at the edge, all inputs are latched, counter=LATENCY-1, and the next state is WAIT (RESP directly if LATENCY=1).
  - WAIT: counter decrements each cycle. When counter=1, the next state is RESP.
  - RESP: resp_valid=1. read_data and access_err hold the result. Next state is IDLE unconditionally.
- Handshake and stall:
  - stall = req_valid & ~resp_valid (combinational).
  - Timeline: accept at edge 0; resp_valid high during cycle LATENCY; MEM/WB captures at the end of that cycle.
  - req_ready=0 in RESP, so the held request is never re-accepted. A new request is accepted in the IDLE cycle after RESP.
  - req_valid=0 in IDLE gives stall=0 and no state change.
- Address decode:
  - index = mem_addr[log2(DEPTH)+2:3]; byte offset = mem_addr[2:0].
  - Misaligned when offset is not a multiple of the access size (h: bit0; w: bits1:0; d: bits2:0).
  - Out of range when mem_addr >= DEPTH*8.
  - funct3=111 is illegal.
- Stores:
  - Committed to the array at the acceptance edge with a byte-lane merge; untouched bytes are preserved.
  - Response carries read_data=0.
  - Errored stores (misaligned, out of range, illegal funct3) write nothing.
- Loads:
  - Array read at acceptance and held until RESP.
  - Selected lane is right-justified.
  - Sign-extended for b/h/w, zero-extended for bu/hu/wu; d is passed unchanged.
  - Errored loads return read_data=0.
- Store then load to the same address on back-to-back requests returns the new data (store committed at its own acceptance).
- read_data and access_err hold their last response value outside RESP. Only resp_valid qualifies them.
- Reset mid-operation:
  - A pending load is discarded; no resp_valid is issued.
  - An accepted store remains committed.
  - Returns to IDLE immediately.
- Input changes during WAIT/RESP are ignored (inputs were latched at acceptance).

Test Plan:
- Aligned dword: store d to 0x10 with write_data=0x1122334455667788, then load d 0x10 → resp_valid in cycle 2 after each accept; read_data=0x1122334455667788; stall high for exactly 2 cycles per access.
- Byte lanes/extension: after the above, store b 0xAA to 0x13, then:
  - load b 0x13 → 0xFFFFFFFFFFFFFFAA
  - load bu 0x13 → 0x00000000000000AA
  - load d 0x10 → 0x11223344AA667788
- Word sign: store w 0x80000001 to 0x20, then:
  - load w → 0xFFFFFFFF80000001
  - load wu → 0x0000000080000001
- Errors:
  - load h at 0x21 → access_err=1, read_data=0.
  - store d at DEPTH*8 → access_err=1; a following load d at 0x0 still returns its prior contents.
- Reset mid-load: accept load, drive reset=0 during WAIT → resp_valid=0, state IDLE, read_data=0. A store accepted before the reset reads back correctly after reset release.
- LATENCY=1 build: back-to-back loads with req_valid held high → one resp every 2 cycles (accept, RESP); req_ready=0 in RESP cycles; no duplicate acceptance.
